// File: rtl/debounce_seq_detector.sv
// Multi-channel button synchroniser/debouncer feeding a programmable press-sequence detector.
// Optional macro SEQ_TIMEOUT_EN adds an inactivity timeout that abandons partial progress.
module debounce_seq_detector #(
    parameter int                            NCH            = 2,
    parameter int                            DB_CYCLES      = 4,
    parameter int                            SEQ_LEN        = 4,
    parameter logic [SEQ_LEN*$clog2(NCH)-1:0] SEQ           = 4'b1011,
    parameter int                            MEALY          = 0,
    parameter int                            CNT_W          = 8,
    parameter int                            TIMEOUT_CYCLES = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   btn_raw,
    output logic [NCH-1:0]   btn_clean,
    output logic [NCH-1:0]   btn_pulse,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic             timeout
);

    localparam int SYM_W = $clog2(NCH);
    localparam int DCW   = $clog2(DB_CYCLES + 1);
    localparam int PW    = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int NW    = $clog2(NCH + 1);

    typedef enum logic {
        ST_RUN,
        ST_MATCH
    } state_t;

    logic [NCH-1:0] sync1;
    logic [NCH-1:0] sync2;
    logic [NCH-1:0] clean;
    logic [NCH-1:0] clean_prev;
    logic [DCW-1:0] db_cnt [NCH];

    // A channel flips only after its synchronised level has disagreed for DB_CYCLES cycles in a row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1      <= '0;
            sync2      <= '0;
            clean      <= '0;
            clean_prev <= '0;
            for (int i = 0; i < NCH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1      <= btn_raw;
            sync2      <= sync1;
            clean_prev <= clean;
            for (int i = 0; i < NCH; i++) begin
                if (sync2[i] != clean[i]) begin
                    if (db_cnt[i] == DCW'(DB_CYCLES - 1)) begin
                        clean[i]  <= ~clean[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign btn_clean = clean;
    assign btn_pulse = clean & ~clean_prev;

    logic [NW-1:0]    n_hot;
    logic [SYM_W-1:0] sym;
    logic             valid;
    logic             illegal;

    always_comb begin
        n_hot = '0;
        sym   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (btn_pulse[i]) begin
                n_hot = n_hot + 1'b1;
                sym   = SYM_W'(i);
            end
        end
        valid   = (n_hot == NW'(1));
        illegal = (n_hot > NW'(1));
    end

    state_t           state;
    state_t           state_nxt;
    logic [PW-1:0]    p;
    logic [PW-1:0]    p_nxt;
    logic [PW-1:0]    base;
    logic [SYM_W-1:0] target;
    logic [SYM_W-1:0] first;
    logic             match_hit;

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt;
    logic [TW-1:0] idle_nxt;
    logic          timeout_nxt;
    logic          timeout_q;
`endif

    // MATCH behaves like progress 0 for the next press, so evaluation always starts from base.
    always_comb begin
        state_nxt = state;
        p_nxt     = p;
        match_hit = 1'b0;
        base      = (state == ST_MATCH) ? '0 : p;
        target    = SEQ[base*SYM_W +: SYM_W];
        first     = SEQ[SYM_W-1:0];
`ifdef SEQ_TIMEOUT_EN
        idle_nxt    = '0;
        timeout_nxt = 1'b0;
`endif
        if (illegal) begin
            state_nxt = ST_RUN;
            p_nxt     = '0;
        end else if (valid) begin
            state_nxt = ST_RUN;
            if (sym == target) begin
                if (base == PW'(SEQ_LEN - 1)) begin
                    match_hit = 1'b1;
                    p_nxt     = '0;
                    state_nxt = (MEALY != 0) ? ST_RUN : ST_MATCH;
                end else begin
                    p_nxt = base + 1'b1;
                end
            end else begin
                p_nxt = (sym == first) ? PW'(1) : '0;
            end
        end
`ifdef SEQ_TIMEOUT_EN
        else if (state == ST_RUN && p != '0) begin
            if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                p_nxt       = '0;
                timeout_nxt = 1'b1;
            end else begin
                idle_nxt = idle_cnt + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_RUN;
            p         <= '0;
            match_cnt <= '0;
        end else begin
            state <= state_nxt;
            p     <= p_nxt;
            if (match_hit && match_cnt != {CNT_W{1'b1}}) begin
                match_cnt <= match_cnt + 1'b1;
            end
        end
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            idle_cnt  <= idle_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout            = 1'b0;
`endif

    // Mealy flags the final press itself; Moore flags it from the registered MATCH state.
    generate
        if (MEALY != 0) begin : g_mealy
            assign z = match_hit;
        end else begin : g_moore
            assign z = (state == ST_MATCH);
        end
    endgenerate

endmodule

// File: tb/tb_debounce_seq_detector.sv
// Self-checking bench for debounce_seq_detector: Moore, Mealy and narrow-counter instances
// checked every cycle against a behavioural model, plus directed literal expectations.
module tb_debounce_seq_detector;

    localparam int         NCH   = 2;
    localparam int         DB    = 4;
    localparam int         L     = 4;
    localparam int         SYM_W = 1;
    localparam int         TO    = 20;
    localparam logic [3:0] SEQV  = 4'b1011;
`ifdef SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic           clk     = 1'b0;
    logic           reset   = 1'b1;
    logic [NCH-1:0] btn_raw = '0;

    logic [NCH-1:0] mo_clean, mo_pulse, me_clean, me_pulse, sa_clean, sa_pulse;
    logic           mo_z, me_z, sa_z, mo_to, me_to, sa_to;
    logic [7:0]     mo_cnt, me_cnt;
    logic [1:0]     sa_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    debounce_seq_detector #(
        .NCH(NCH), .DB_CYCLES(DB), .SEQ_LEN(L), .SEQ(SEQV),
        .MEALY(0), .CNT_W(8), .TIMEOUT_CYCLES(TO)
    ) dut_moore (
        .clk(clk), .reset(reset), .btn_raw(btn_raw),
        .btn_clean(mo_clean), .btn_pulse(mo_pulse), .z(mo_z),
        .match_cnt(mo_cnt), .timeout(mo_to)
    );

    debounce_seq_detector #(
        .NCH(NCH), .DB_CYCLES(DB), .SEQ_LEN(L), .SEQ(SEQV),
        .MEALY(1), .CNT_W(8), .TIMEOUT_CYCLES(TO)
    ) dut_mealy (
        .clk(clk), .reset(reset), .btn_raw(btn_raw),
        .btn_clean(me_clean), .btn_pulse(me_pulse), .z(me_z),
        .match_cnt(me_cnt), .timeout(me_to)
    );

    debounce_seq_detector #(
        .NCH(NCH), .DB_CYCLES(DB), .SEQ_LEN(L), .SEQ(SEQV),
        .MEALY(0), .CNT_W(2), .TIMEOUT_CYCLES(TO)
    ) dut_sat (
        .clk(clk), .reset(reset), .btn_raw(btn_raw),
        .btn_clean(sa_clean), .btn_pulse(sa_pulse), .z(sa_z),
        .match_cnt(sa_cnt), .timeout(sa_to)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model state: raw samples pass two sync stages, and a channel's clean level
    // flips once the last DB synchronised samples since its previous flip all disagree with it.
    logic [NCH-1:0] s1_m, s2_m, clean_m, cprev_m;
    bit             hist [NCH][$];
    int             p_m, idle_m, cnt_m, cnt_sat_m;
    bit             in_match_m, to_m;

    function automatic int seqSym(input int k);
        int v;
        v = int'(SEQV);
        return (v >> (k * SYM_W)) & ((1 << SYM_W) - 1);
    endfunction

    function automatic int popCount(input logic [NCH-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < NCH; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic int firstSym(input logic [NCH-1:0] v);
        int s;
        s = 0;
        for (int i = 0; i < NCH; i++) if (v[i]) s = i;
        return s;
    endfunction

    function automatic bit mealyZ();
        logic [NCH-1:0] pulse;
        pulse = clean_m & ~cprev_m;
        return (popCount(pulse) == 1) && (p_m == L - 1) && (firstSym(pulse) == seqSym(L - 1));
    endfunction

    task automatic modelReset();
        s1_m = '0; s2_m = '0; clean_m = '0; cprev_m = '0;
        p_m = 0; idle_m = 0; cnt_m = 0; cnt_sat_m = 0;
        in_match_m = 1'b0; to_m = 1'b0;
        for (int ch = 0; ch < NCH; ch++) hist[ch].delete();
    endtask

    task automatic modelStep();
        logic [NCH-1:0] pulse, newClean;
        int n, s;
        bit allDiff;
        pulse = clean_m & ~cprev_m;
        n     = popCount(pulse);
        s     = firstSym(pulse);
        to_m  = 1'b0;
        if (n > 1) begin
            p_m = 0; in_match_m = 1'b0; idle_m = 0;
        end else if (n == 1) begin
            in_match_m = 1'b0;
            idle_m     = 0;
            if (s == seqSym(p_m)) begin
                if (p_m == L - 1) begin
                    p_m        = 0;
                    in_match_m = 1'b1;
                    if (cnt_m < 255) cnt_m++;
                    if (cnt_sat_m < 3) cnt_sat_m++;
                end else begin
                    p_m++;
                end
            end else begin
                p_m = (s == seqSym(0)) ? 1 : 0;
            end
        end
`ifdef SEQ_TIMEOUT_EN
        else if (p_m > 0) begin
            idle_m++;
            if (idle_m == TO) begin
                idle_m = 0; p_m = 0; to_m = 1'b1;
            end
        end
`endif
        newClean = clean_m;
        for (int ch = 0; ch < NCH; ch++) begin
            hist[ch].push_back(s2_m[ch]);
            if (hist[ch].size() > DB) void'(hist[ch].pop_front());
            if (hist[ch].size() == DB) begin
                allDiff = 1'b1;
                for (int j = 0; j < DB; j++) if (hist[ch][j] == clean_m[ch]) allDiff = 1'b0;
                if (allDiff) begin
                    newClean[ch] = ~clean_m[ch];
                    hist[ch].delete();
                end
            end
        end
        cprev_m = clean_m;
        clean_m = newClean;
        s2_m    = s1_m;
        s1_m    = btn_raw;
    endtask

    // The model advances on every clock edge and clears the moment reset rises.
    initial begin
        modelReset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) modelReset();
            else modelStep();
        end
    end

    task automatic checkAll();
        logic [NCH-1:0] pexp;
        pexp = clean_m & ~cprev_m;
        checkOutput("moore_clean", mo_clean, clean_m);
        checkOutput("mealy_clean", me_clean, clean_m);
        checkOutput("sat_clean", sa_clean, clean_m);
        checkOutput("moore_pulse", mo_pulse, pexp);
        checkOutput("mealy_pulse", me_pulse, pexp);
        checkOutput("sat_pulse", sa_pulse, pexp);
        checkOutput("moore_z", mo_z, in_match_m);
        checkOutput("sat_z", sa_z, in_match_m);
        checkOutput("mealy_z", me_z, mealyZ());
        checkOutput("moore_cnt", mo_cnt, cnt_m);
        checkOutput("mealy_cnt", me_cnt, cnt_m);
        checkOutput("sat_cnt", sa_cnt, cnt_sat_m);
        checkOutput("moore_timeout", mo_to, to_m);
        checkOutput("mealy_timeout", me_to, to_m);
        checkOutput("sat_timeout", sa_to, to_m);
    endtask

    // Continuous comparison half a cycle away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            checkAll();
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drives a clean press and returns one step into the cycle its pulse is visible.
    task automatic applyStimulus(input logic [NCH-1:0] pattern);
        @(negedge clk);
        btn_raw = pattern;
        repeat (DB + 2) @(posedge clk);
        #1;
    endtask

    task automatic releaseButtons();
        @(negedge clk);
        btn_raw = '0;
        repeat (DB + 4) @(negedge clk);
    endtask

    task automatic pressAndCheck(input int ch, input logic expZ, input string tag);
        applyStimulus(NCH'(1) << ch);
        checkOutput({tag, "_mealy_z"}, me_z, expZ);
        releaseButtons();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_mo_clean"}, mo_clean, 0);
        checkOutput({tag, "_mo_pulse"}, mo_pulse, 0);
        checkOutput({tag, "_mo_z"}, mo_z, 0);
        checkOutput({tag, "_mo_cnt"}, mo_cnt, 0);
        checkOutput({tag, "_mo_to"}, mo_to, 0);
        checkOutput({tag, "_me_z"}, me_z, 0);
        checkOutput({tag, "_me_cnt"}, me_cnt, 0);
        checkOutput({tag, "_sa_cnt"}, sa_cnt, 0);
    endtask

    task automatic randomPress();
        logic [NCH-1:0] pat;
        int nb;
        if ($urandom_range(0, 7) == 0) pat = '1;
        else pat = NCH'(1) << (($urandom_range(0, 9) < 7) ? 1 : 0);
        nb = $urandom_range(0, 3);
        for (int j = 0; j < nb; j++) begin
            @(negedge clk);
            btn_raw = btn_raw ^ pat;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        @(negedge clk);
        btn_raw = pat;
        repeat ($urandom_range(DB + 2, DB + 8)) @(negedge clk);
        nb = $urandom_range(0, 3);
        for (int j = 0; j < nb; j++) begin
            @(negedge clk);
            btn_raw = btn_raw ^ pat;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        @(negedge clk);
        btn_raw = '0;
        repeat ($urandom_range(DB + 2, DB + 10)) @(negedge clk);
    endtask

    initial begin
        int pulses;
        int toCount;
        $display("[TB] start");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkAllZero("reset");

        // Ten one-cycle bounces, then a steady high level.
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pulses += int'(mo_pulse[0]);
            btn_raw[0] = (i % 2 == 0);
        end
        @(negedge clk);
        pulses += int'(mo_pulse[0]);
        btn_raw[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            pulses += int'(mo_pulse[0]);
            if (k == 5) checkOutput("bounce_clean_before", mo_clean[0], 0);
            if (k == 6) begin
                checkOutput("bounce_clean_after", mo_clean[0], 1);
                checkOutput("bounce_pulse", mo_pulse[0], 1);
            end
        end
        checkOutput("bounce_pulse_count", pulses, 1);
        releaseButtons();

        // ch1,ch1,ch0,ch1: Mealy flags the final pulse, Moore flags the following cycles.
        pressAndCheck(1, 1'b0, "s3a");
        pressAndCheck(1, 1'b0, "s3b");
        pressAndCheck(0, 1'b0, "s3c");
        applyStimulus(2'b10);
        checkOutput("s3_final_mealy_z", me_z, 1);
        checkOutput("s3_final_moore_z", mo_z, 0);
        checkOutput("s3_final_cnt", mo_cnt, 0);
        @(posedge clk);
        #1;
        checkOutput("s3_after_moore_z", mo_z, 1);
        checkOutput("s3_after_mealy_z", me_z, 0);
        checkOutput("s3_after_moore_cnt", mo_cnt, 1);
        checkOutput("s3_after_mealy_cnt", me_cnt, 1);
        releaseButtons();
        checkOutput("s3_hold_moore_z", mo_z, 1);
        applyStimulus(2'b01);
        checkOutput("s3_next_press_moore_z", mo_z, 1);
        @(posedge clk);
        #1;
        checkOutput("s3_cleared_moore_z", mo_z, 0);
        releaseButtons();

        // A mismatch restarts at progress 1 at most, so this five-press run never completes.
        pressAndCheck(1, 1'b0, "s4a");
        pressAndCheck(1, 1'b0, "s4b");
        pressAndCheck(1, 1'b0, "s4c");
        pressAndCheck(0, 1'b0, "s4d");
        pressAndCheck(1, 1'b0, "s4e");
        checkOutput("s4_cnt_unchanged", mo_cnt, 1);
        pressAndCheck(0, 1'b0, "s4f");
        pressAndCheck(1, 1'b0, "s4g");
        pressAndCheck(0, 1'b0, "s4h");
        pressAndCheck(1, 1'b0, "s4i");
        pressAndCheck(1, 1'b0, "s4j");
        pressAndCheck(0, 1'b0, "s4k");
        pressAndCheck(1, 1'b1, "s4l");
        checkOutput("s4_cnt_matched", mo_cnt, 2);

        // Simultaneous pulses are an illegal event that wipes progress.
        pressAndCheck(1, 1'b0, "s5a");
        pressAndCheck(1, 1'b0, "s5b");
        applyStimulus(2'b11);
        checkOutput("s5_both_pulse", mo_pulse, 2'b11);
        checkOutput("s5_both_mealy_z", me_z, 0);
        releaseButtons();
        checkOutput("s5_both_moore_z", mo_z, 0);
        pressAndCheck(0, 1'b0, "s5c");
        pressAndCheck(1, 1'b0, "s5d");
        checkOutput("s5_cnt", mo_cnt, 2);

        // Reset asserted mid-cycle with three presses of progress outstanding.
        pressAndCheck(0, 1'b0, "s6a");
        pressAndCheck(1, 1'b0, "s6b");
        pressAndCheck(1, 1'b0, "s6c");
        pressAndCheck(0, 1'b0, "s6d");
        checkOutput("s6_pre_cnt", mo_cnt, 2);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkAllZero("s6_midreset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        pressAndCheck(1, 1'b0, "s6e");
        checkOutput("s6_post_cnt", mo_cnt, 0);
        checkOutput("s6_post_moore_z", mo_z, 0);

        // Long idle gap after two presses.
        pressAndCheck(0, 1'b0, "s7a");
        pressAndCheck(1, 1'b0, "s7b");
        pressAndCheck(1, 1'b0, "s7c");
        toCount = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            toCount += int'(mo_to);
        end
        checkOutput("s7_timeout_pulses", toCount, TO_EN ? 1 : 0);
        pressAndCheck(0, 1'b0, "s7d");
        pressAndCheck(1, ~TO_EN, "s7e");
        checkOutput("s7_cnt", mo_cnt, TO_EN ? 0 : 1);

        // Four back-to-back matches push the two-bit counter into saturation.
        pressAndCheck(0, 1'b0, "s8n");
        for (int r = 0; r < 4; r++) begin
            pressAndCheck(1, 1'b0, "s8a");
            pressAndCheck(1, 1'b0, "s8b");
            pressAndCheck(0, 1'b0, "s8c");
            pressAndCheck(1, 1'b1, "s8d");
        end
        checkOutput("s8_moore_cnt", mo_cnt, TO_EN ? 4 : 5);
        checkOutput("s8_mealy_cnt", me_cnt, TO_EN ? 4 : 5);
        checkOutput("s8_sat_cnt", sa_cnt, 3);

        // Randomised presses with bounce, then raw noise with one asynchronous reset.
        for (int i = 0; i < 150; i++) randomPress();
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (i == 700) begin
                @(posedge clk);
                #3;
                reset = 1'b1;
                @(negedge clk);
                @(negedge clk);
                reset = 1'b0;
            end
            for (int ch = 0; ch < NCH; ch++) begin
                if ($urandom_range(0, 3) == 0) btn_raw[ch] = ~btn_raw[ch];
            end
        end
        btn_raw = '0;
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
